reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Integer register file (x0–x31) of the 5-stage RISC-V pipeline.
- Receives the write-back stage's outputs (reg_write_w_out, rd_w, result_w) on its write port.
- Serves the decode stage's two source-operand reads.
- Provides same-cycle write-through bypass, so decode sees a value retiring in WB without an extra stall cycle.
- Also exposes a debug read port and a retired-write counter for bench/trace use.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register index width, equal to $clog2(NREGS).
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- srst  in  1  synchronous reset, active-high.
- reg_write_w  in  1  write enable from write-back stage.
- rd_w  in  AW  destination register index from write-back stage.
- result_w  in  XLEN  write data from write-back result mux.
- rs1_d  in  AW  source register 1 index from decode.
- rs2_d  in  AW  source register 2 index from decode.
- rd1_d  out  XLEN  source 1 operand.
- rd2_d  out  XLEN  source 2 operand.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  XLEN  debug read data; raw array value, no bypass.
- wr_count  out  CNT_W  number of committed non-x0 writes since reset.

Behaviour:
- Clock and reset: one clock (clk); reset srst is synchronous and active-high.
- Storage: NREGS x XLEN register array; entry 0 is never written and always reads 0.
- Write rule: at posedge clk, when srst=0, reg_write_w=1 and rd_w!=0, then reg[rd_w] <= result_w.
  - A write with rd_w=0 is discarded and does not count.
- Read ports rd1_d/rd2_d are combinational (zero-latency) functions of rsN_d, array state and the write port:
  - if rsN_d==0, output 0;
  - else if srst=0, reg_write_w=1 and rd_w==rsN_d, output result_w (bypass);
  - else output reg[rsN_d].
- Both read ports may address the same register and may both bypass in the same cycle.
- dbg_data = reg[dbg_addr], with 0 for index 0. It has no bypass, so it shows the post-edge value one cycle after a write.
- wr_count: increments by 1 at posedge on every committed write (as defined in the write rule). Wraps from 2^CNT_W−1 to 0 with no saturation or flag.
- Reset: at posedge clk with srst=1, all registers are cleared to 0 and wr_count is set to 0.
  - A write presented in the same cycle as srst is dropped.
  - Bypass is disabled while srst=1, so reads return the current (pre-clear) array contents.
  - From the cycle after srst deasserts, all reads return 0 until written.
- Reset mid-operation: an in-flight write coincident with srst is lost; there is no partial update.
- X-safety: when reg_write_w=0, the values of rd_w and result_w must not affect any output or state.
- Back-to-back writes to the same register commit in order, last write wins.
  - A read in the cycle of the second write returns the second write's data via bypass.
- No internal pipeline registers on the read path; the write path has 1-cycle latency into the array, 0-cycle latency via bypass.

Decomposition:
- Shared package (riscv_pkg): XLEN, NREGS, AW constants; the reg_idx_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]) typedefs.
- The same package is reused by decode and write-back stages.
- One natural sub-module, regfile_read_port:
  - contains zero-index, bypass and array-select logic;
  - instantiated twice (rs1, rs2);
  - the debug port uses the same module with bypass tied off.
- The array and counter stay in the top-level module.

Test Plan:
1. Reset then read:
   - Stimulus: assert srst for 2 cycles with the array preloaded by writes; deassert; read rs1_d=5, rs2_d=31, dbg_addr=7.
   - Required response: rd1_d=0, rd2_d=0, dbg_data=0, wr_count=0.
2. Basic write/read:
   - Stimulus: write x3=0xDEAD_BEEF; next cycle rs1_d=3.
   - Required response: rd1_d=0xDEAD_BEEF, dbg_data at addr 3 = 0xDEAD_BEEF, wr_count=1.
3. Bypass:
   - Stimulus: same cycle reg_write_w=1, rd_w=10, result_w=0x1234_5678, rs1_d=10, rs2_d=10; reg[10] previously 0xAAAA_AAAA.
   - Required response: rd1_d=rd2_d=0x1234_5678 in that cycle; dbg_data at addr 10 = 0xAAAA_AAAA that cycle and 0x1234_5678 next cycle.
4. x0 protection:
   - Stimulus: write rd_w=0, result_w=0xFFFF_FFFF with rs1_d=0 in the same cycle.
   - Required response: rd1_d=0 that cycle and the next; wr_count unchanged.
5. Reset collision:
   - Stimulus: srst=1 in the same cycle as a write of x8=0x55 with rs1_d=8; reg[8]=0x11.
   - Required response: rd1_d=0x11 (no bypass) in that cycle; after the edge reg[8]=0 and wr_count=0.
6. Counter wrap:
   - Stimulus: with CNT_W=4, perform 17 writes to x1.
   - Required response: wr_count reads 15 after 15 writes, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and typedefs for the 5-stage RISC-V pipeline.
// Decode, write-back and the register file all import this package.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] xlen_t;

endpackage : riscv_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port.
// Handles the x0 zero rule, optional write-through bypass and array select.
module regfile_read_port
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int NREGS  = riscv_pkg::NREGS,
   parameter int AW     = riscv_pkg::AW,
   parameter bit BYPASS = 1'b1
) (
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] regs [NREGS],
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] data
);

   // wr_en must already be qualified by reset so rd_w/result_w never leak through
   always_comb begin
      data = regs[addr];
      if (addr == '0) begin
         data = '0;
      end else if (BYPASS && wr_en && (wr_addr == addr)) begin
         data = wr_data;
      end
   end

endmodule : regfile_read_port

// File: rtl/reg_file_wb.sv
// Integer register file x0-x31 with same-cycle WB bypass, a raw debug
// read port and a counter of committed non-x0 writes.
module reg_file_wb
   import riscv_pkg::*;
#(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int NREGS = riscv_pkg::NREGS,
   parameter int AW    = riscv_pkg::AW,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             reg_write_w,
   input  logic [AW-1:0]    rd_w,
   input  logic [XLEN-1:0]  result_w,
   input  logic [AW-1:0]    rs1_d,
   input  logic [AW-1:0]    rs2_d,
   output logic [XLEN-1:0]  rd1_d,
   output logic [XLEN-1:0]  rd2_d,
   input  logic [AW-1:0]    dbg_addr,
   output logic [XLEN-1:0]  dbg_data,
   output logic [CNT_W-1:0] wr_count
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_live;
   logic            commit;

   // Bypass is suppressed during reset; commit additionally excludes x0
   assign wr_live = reg_write_w && !srst;
   assign commit  = wr_live && (rd_w != '0);

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (commit) begin
         regs[rd_w] <= result_w;
         wr_count   <= wr_count + CNT_W'(1);
      end
   end

   regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b1)) u_rs1 (
      .addr    (rs1_d),
      .regs    (regs),
      .wr_en   (wr_live),
      .wr_addr (rd_w),
      .wr_data (result_w),
      .data    (rd1_d)
   );

   regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b1)) u_rs2 (
      .addr    (rs2_d),
      .regs    (regs),
      .wr_en   (wr_live),
      .wr_addr (rd_w),
      .wr_data (result_w),
      .data    (rd2_d)
   );

   // Debug port shows raw array contents only
   regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1'b0)) u_dbg (
      .addr    (dbg_addr),
      .regs    (regs),
      .wr_en   (1'b0),
      .wr_addr ('0),
      .wr_data ('0),
      .data    (dbg_data)
   );

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: one vector table for reads/bypass/reset,
// plus a hand sequence for counter wrap on a narrow-counter instance.
module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        srst;
   logic        reg_write_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  dbg_addr;
   logic [31:0] rd1_d, rd2_d, dbg_data;
   logic [31:0] wr_count;
   logic [31:0] rd1_n, rd2_n, dbg_n;
   logic [3:0]  wr_count_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_file_wb dut (
      .clk         (clk),
      .srst        (srst),
      .reg_write_w (reg_write_w),
      .rd_w        (rd_w),
      .result_w    (result_w),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd1_d       (rd1_d),
      .rd2_d       (rd2_d),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .wr_count    (wr_count)
   );

   reg_file_wb #(.CNT_W(4)) dut_narrow (
      .clk         (clk),
      .srst        (srst),
      .reg_write_w (reg_write_w),
      .rd_w        (rd_w),
      .result_w    (result_w),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd1_d       (rd1_n),
      .rd2_d       (rd2_n),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_n),
      .wr_count    (wr_count_n)
   );

   typedef struct {
      logic        srst;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  dbg;
      logic [31:0] exp_rd1;
      logic [31:0] exp_rd2;
      logic [31:0] exp_dbg;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [16];

   task automatic apply_stimulus(input vec_t v);
      srst        = v.srst;
      reg_write_w = v.we;
      rd_w        = v.rd;
      result_w    = v.wd;
      rs1_d       = v.rs1;
      rs2_d       = v.rs2;
      dbg_addr    = v.dbg;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   initial begin
      // srst, we, rd, wd, rs1, rs2, dbg, rd1, rd2, dbg, cnt (all sampled before the edge)
      vecs[0]  = '{0, 1,  5, 32'h0000_5555,  5,  0,  5, 32'h0000_5555, 32'h0,         32'h0,         0};
      vecs[1]  = '{0, 1, 31, 32'h3131_3131,  5, 31,  5, 32'h0000_5555, 32'h3131_3131, 32'h0000_5555, 1};
      vecs[2]  = '{0, 1,  7, 32'h0707_0707, 31,  7, 31, 32'h3131_3131, 32'h0707_0707, 32'h3131_3131, 2};
      vecs[3]  = '{1, 0,  0, 32'h0,          5, 31,  7, 32'h0000_5555, 32'h3131_3131, 32'h0707_0707, 3};
      vecs[4]  = '{1, 1,  5, 32'hFFFF_0000,  5, 31,  7, 32'h0,         32'h0,         32'h0,         0};
      vecs[5]  = '{0, 0,  0, 32'h0,          5, 31,  7, 32'h0,         32'h0,         32'h0,         0};
      vecs[6]  = '{0, 1,  3, 32'hDEAD_BEEF,  3,  0,  3, 32'hDEAD_BEEF, 32'h0,         32'h0,         0};
      vecs[7]  = '{0, 0,  3, 32'h0001_2345,  3,  3,  3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
      vecs[8]  = '{0, 1, 10, 32'hAAAA_AAAA,  0,  0, 10, 32'h0,         32'h0,         32'h0,         1};
      vecs[9]  = '{0, 1, 10, 32'h1234_5678, 10, 10, 10, 32'h1234_5678, 32'h1234_5678, 32'hAAAA_AAAA, 2};
      vecs[10] = '{0, 0, 10, 32'hBAD0_0BAD, 10,  3, 10, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 3};
      vecs[11] = '{0, 1,  0, 32'hFFFF_FFFF,  0, 10,  0, 32'h0,         32'h1234_5678, 32'h0,         3};
      vecs[12] = '{0, 0,  0, 32'h0,          0,  0,  0, 32'h0,         32'h0,         32'h0,         3};
      vecs[13] = '{0, 1,  8, 32'h0000_0011,  8,  0,  8, 32'h0000_0011, 32'h0,         32'h0,         3};
      vecs[14] = '{1, 1,  8, 32'h0000_0055,  8,  3,  8, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0011, 4};
      vecs[15] = '{0, 0,  0, 32'h0,          8,  3,  8, 32'h0,         32'h0,         32'h0,         0};

      srst = 1'b1; reg_write_w = 1'b0; rd_w = '0; result_w = '0;
      rs1_d = '0; rs2_d = '0; dbg_addr = '0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i]);
         #2;
         check_output($sformatf("v%0d_rd1", i), rd1_d, vecs[i].exp_rd1);
         check_output($sformatf("v%0d_rd2", i), rd2_d, vecs[i].exp_rd2);
         check_output($sformatf("v%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
         check_output($sformatf("v%0d_cnt", i), wr_count, vecs[i].exp_cnt);
         check_output($sformatf("v%0d_cnt_narrow", i), {28'h0, wr_count_n},
                      vecs[i].exp_cnt & 32'hF);
         @(posedge clk); #1;
      end

      // Counter wrap: 17 back-to-back writes to x1 after a fresh reset
      srst = 1'b1; reg_write_w = 1'b0;
      @(posedge clk); #1;
      srst = 1'b0;
      rs1_d = 5'd1; dbg_addr = 5'd1;
      for (int n = 1; n <= 17; n++) begin
         reg_write_w = 1'b1; rd_w = 5'd1; result_w = 32'h100 + 32'(n);
         @(posedge clk); #1;
         reg_write_w = 1'b0;
         #1;
         check_output($sformatf("wrap%0d_cnt_narrow", n), {28'h0, wr_count_n}, 32'(n % 16));
         check_output($sformatf("wrap%0d_cnt", n), wr_count, 32'(n));
         check_output($sformatf("wrap%0d_dbg", n), dbg_data, 32'h100 + 32'(n));
      end
      #1;
      check_output("wrap_last_rd1", rd1_d, 32'h111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_file_wb
